seq_detect_param: RTL
=====================

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
- REQ-001: Parameter PAT_W, default 4; pattern length in bits, legal range 2..16.
- REQ-002: Parameter CNT_W, default 8; match-counter width in bits, minimum 2.
- REQ-003: Parameter OVERLAP, default 1; 1 = overlapping detection, 0 = non-overlapping detection.
- REQ-004: clk  input  1  single clock; all state changes occur on its rising edge.
- REQ-005: reset  input  1  asynchronous, active-low reset.
- REQ-006: i_en  input  1  bit-valid strobe; i_x is sampled only when this is 1.
- REQ-007: i_x  input  1  serial data bit.
- REQ-008: i_load  input  1  load i_pattern and re-arm the detector.
- REQ-009: i_pattern  input  PAT_W  target pattern; bit PAT_W-1 is the oldest (first-received) bit.
- REQ-010: i_clr_cnt  input  1  synchronous clear of o_count and o_sat.
- REQ-011: o_z  output  1  registered one-cycle match pulse.
- REQ-012: o_count  output  CNT_W  saturating count of matches.
- REQ-013: o_sat  output  1  sticky flag; 1 when o_count has reached its maximum value.
- REQ-014: o_armed  output  1  1 once a pattern has been loaded (state is not IDLE).

Function
- REQ-015: The FSM SHALL have three states: IDLE (no pattern loaded), FILL (fill < PAT_W), HUNT (fill == PAT_W).
- REQ-016: Internal state SHALL comprise a pattern register (PAT_W bits), a history shift register (PAT_W bits) and a fill counter (0..PAT_W).
- REQ-017: On an edge with i_load=1, from any state, the block SHALL load the pattern register from i_pattern, clear history and fill, and enter FILL.
- REQ-018: i_load SHALL have priority over i_en; an i_x bit presented in the same cycle is discarded.
- REQ-019: In IDLE, i_en/i_x SHALL be ignored, and o_z SHALL stay 0.
- REQ-020: In FILL or HUNT, on an edge with i_en=1 and i_load=0:
  - history <= {history[PAT_W-2:0], i_x};
  - fill SHALL increment, saturating at PAT_W;
  - the state SHALL move FILL -> HUNT when fill reaches PAT_W.
- REQ-021: A match SHALL occur at an edge where the bit is accepted, the post-shift fill equals PAT_W, and the post-shift history equals the pattern register.
- REQ-022: On a match, o_z SHALL be 1 for exactly the one cycle following that edge; otherwise o_z SHALL be 0.
- REQ-023: On a match with OVERLAP=1, history and fill SHALL be retained, so later bits can complete an overlapping match.
- REQ-024: On a match with OVERLAP=0, fill SHALL be set to 0 and the state SHALL return to FILL, so a new match needs PAT_W fresh bits.
- REQ-025: Cycles with i_en=0 SHALL leave history, fill, state and o_count unchanged and drive o_z=0.
- REQ-026: o_count SHALL increment by 1 per match and saturate at 2^CNT_W-1 without wrapping.
- REQ-027: o_sat SHALL be set in the cycle in which o_count reaches 2^CNT_W-1.
- REQ-028: i_clr_cnt=1 SHALL clear o_count and o_sat to 0 at the next edge.
- REQ-029: If i_clr_cnt coincides with a match, the clear SHALL win (o_count=0), but o_z SHALL still pulse.
- REQ-030: i_load SHALL NOT affect o_count or o_sat.

Reset
- REQ-031: While reset=0, the following SHALL be forced immediately, independent of clk:
  - state = IDLE;
  - pattern, history and fill = 0;
  - o_z = 0, o_count = 0, o_sat = 0, o_armed = 0.
- REQ-032: After reset is released, the block SHALL detect nothing until i_load is asserted.
- REQ-033: Reset asserted mid-stream SHALL discard any partial match and the loaded pattern.

Verification (PAT_W=4, pattern 4'b1011 unless stated)
- REQ-034: Reset: hold reset=0 for 2 cycles, toggling i_x/i_en -> o_z=0, o_count=0, o_sat=0, o_armed=0.
- REQ-035: Overlap: OVERLAP=1, load, stream 1,0,1,1,0,1,1 with i_en=1 -> o_z pulses after bits 4 and 7; o_count=2.
- REQ-036: Non-overlap: OVERLAP=0, same stream -> o_z pulses after bit 4 only; o_count=1.
- REQ-037: Gaps: stream 1,0,1,1 with an i_en=0 cycle between each bit (i_x toggling during gaps) -> exactly one o_z pulse, after the 4th accepted bit.
- REQ-038: Saturation: CNT_W=2, produce 4 matches -> o_count=3, o_sat=1 after the 3rd match; then i_clr_cnt=1 -> o_count=0, o_sat=0.
- REQ-039: Mid-stream reset/reload:
  - send 1,0,1, then pulse reset -> IDLE, and a following 1 gives no o_z;
  - then i_load with i_x=1, i_en=1 in the same cycle -> bit discarded, fill=0.

Source files
------------

// File: rtl/seq_detect_param.sv
// Parameterised serial pattern detector with a saturating match counter.
// A pattern is loaded at run time; each accepted bit shifts into a history
// register, and a match pulses o_z for one cycle and bumps o_count.
module seq_detect_param #(
   parameter int PAT_W   = 4,
   parameter int CNT_W   = 8,
   parameter int OVERLAP = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_en,
   input  logic             i_x,
   input  logic             i_load,
   input  logic [PAT_W-1:0] i_pattern,
   input  logic             i_clr_cnt,
   output logic             o_z,
   output logic [CNT_W-1:0] o_count,
   output logic             o_sat,
   output logic             o_armed
);

   localparam int unsigned FILL_W = $clog2(PAT_W + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      HUNT = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [PAT_W-1:0]   pat_q,   pat_d;
   logic [PAT_W-1:0]   hist_q,  hist_d;
   logic [FILL_W-1:0]  fill_q,  fill_d;
   logic               z_q,     z_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;
   logic               sat_q,   sat_d;

   logic               accept;
   logic [PAT_W-1:0]   hist_shift;
   logic [FILL_W-1:0]  fill_inc;
   logic               match;

   // Bit acceptance, post-shift history/fill and the match decision.
   always_comb begin
      accept     = i_en && !i_load && (state_q != IDLE);
      hist_shift = {hist_q[PAT_W-2:0], i_x};
      fill_inc   = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;
      match      = accept && (fill_inc == FILL_FULL) && (hist_shift == pat_q);
   end

   // Next-state logic for the FSM, pattern/history/fill and match pulse.
   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      hist_d  = hist_q;
      fill_d  = fill_q;
      z_d     = match;
      if (i_load) begin
         pat_d   = i_pattern;
         hist_d  = '0;
         fill_d  = '0;
         state_d = FILL;
      end else if (accept) begin
         hist_d  = hist_shift;
         fill_d  = fill_inc;
         state_d = (fill_inc == FILL_FULL) ? HUNT : FILL;
         // Non-overlapping mode demands PAT_W fresh bits after a match;
         // stale history is harmless because fill must refill completely.
         if (match && (OVERLAP == 0)) begin
            fill_d  = '0;
            state_d = FILL;
         end
      end
   end

   // Saturating match counter; a clear beats a coincident match.
   always_comb begin
      cnt_d = cnt_q;
      if (i_clr_cnt) begin
         cnt_d = '0;
      end else if (match && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end
      sat_d = (cnt_d == CNT_MAX);
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         pat_q   <= '0;
         hist_q  <= '0;
         fill_q  <= '0;
         z_q     <= 1'b0;
         cnt_q   <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         z_q     <= z_d;
         cnt_q   <= cnt_d;
         sat_q   <= sat_d;
      end
   end

   assign o_z     = z_q;
   assign o_count = cnt_q;
   assign o_sat   = sat_q;
   assign o_armed = (state_q != IDLE);

endmodule
